// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-deep holding register.
// Queued bytes follow the stop bit with no idle gap.
module uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_rdy,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = $clog2(BAUD_DIV);

  typedef enum logic {
    IDLE,
    TRANSMIT
  } state_t;

  state_t        state;
  logic [9:0]    shift_reg;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    hold;
  logic          hold_full;
  logic          shift;
  logic          frame_done;

  assign shift = (state == TRANSMIT) &&
                 (baud_cnt == CW'(BAUD_DIV - 1));

  // Tenth shift: stop bit has just completed.
  assign frame_done = shift && (bit_cnt == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= 10'h3FF;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      TX        <= 1'b1;
      busy      <= 1'b0;
      tx_rdy    <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (trmt) begin
            state     <= TRANSMIT;
            shift_reg <= {1'b1, tx_data, 1'b0};
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            TX        <= 1'b0;
            busy      <= 1'b1;
            tx_done   <= 1'b0;
          end
        end
        TRANSMIT: begin
          if (frame_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            unique case (1'b1)
              hold_full: begin
                shift_reg <= {1'b1, hold, 1'b0};
                TX        <= 1'b0;
                hold_full <= trmt;
                tx_rdy    <= !trmt;
                if (trmt) hold <= tx_data;
              end
              trmt: begin
                shift_reg <= {1'b1, tx_data, 1'b0};
                TX        <= 1'b0;
                tx_done   <= 1'b0;
              end
              default: begin
                state     <= IDLE;
                shift_reg <= 10'h3FF;
                TX        <= 1'b1;
                busy      <= 1'b0;
                tx_done   <= 1'b1;
              end
            endcase
          end else begin
            if (shift) begin
              shift_reg <= {1'b1, shift_reg[9:1]};
              TX        <= shift_reg[1];
              baud_cnt  <= '0;
              bit_cnt   <= bit_cnt + 4'd1;
            end else begin
              baud_cnt  <= baud_cnt + 1'b1;
            end
            if (trmt && !hold_full) begin
              hold      <= tx_data;
              hold_full <= 1'b1;
              tx_rdy    <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
